rel_fifo_pop_stage: RTL and testbench

TMR-protected pop-side output stage placed directly downstream of the reliable FIFO. It turns the FIFO's empty/pop interface into a registered valid/ready stream. The handshake state is held in three replicas, and each replica votes its next state against the other two before it is registered. The ECC-encoded data word passes through unmodified into a single clock-gated output register, and any replica disagreement is reported on `fault_o`.

---
 rtl/rel_fifo_pop_stage.sv | 144 ++++++++++++++
 tb/tb_rel_fifo_pop_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rel_fifo_pop_stage.sv
// TMR-protected pop stage: turns a FIFO empty/pop interface into a registered valid/ready stream.
// Define REL_FIFO_POP_STAGE_STICKY_FAULT_EN to make fault_o a registered, sticky flag cleared by flush.
module rel_fifo_pop_stage #(
    parameter int unsigned DataWidth = 39,
    parameter bit          TmrStatus = 1'b0,
    parameter int unsigned HsWidth   = TmrStatus ? 3 : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [HsWidth-1:0]   flush_i,
    input  logic [HsWidth-1:0]   fifo_empty_i,
    input  logic [DataWidth-1:0] fifo_data_i,
    output logic [HsWidth-1:0]   fifo_pop_o,
    output logic [HsWidth-1:0]   valid_o,
    input  logic [HsWidth-1:0]   ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 fault_o
);
    localparam int unsigned NumRep = 3;
    localparam logic        EMPTY  = 1'b0;
    localparam logic        FULL   = 1'b1;

    function automatic logic maj3(input logic [NumRep-1:0] v);
        return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
    endfunction

    function automatic logic split3(input logic [NumRep-1:0] v);
        return (|v) & ~(&v);
    endfunction

    logic [NumRep-1:0]    empty_r;
    logic [NumRep-1:0]    ready_r;
    logic [NumRep-1:0]    flush_r;
    logic [NumRep-1:0]    vld_q;
    logic [NumRep-1:0]    vld_d;
    logic [NumRep-1:0]    vld_n;
    logic [NumRep-1:0]    pop;
    logic                 load;
    logic                 vld_vote;
    logic                 ready_vote;
    logic                 flush_vote;
    logic                 mismatch;
    logic [DataWidth-1:0] data_q;

    // Replica inputs: per-replica bits, or one bit fanned out to all three
    if (TmrStatus) begin : g_tmr_in
        assign empty_r = fifo_empty_i;
        assign ready_r = ready_i;
        assign flush_r = flush_i;
    end else begin : g_fan_in
        assign empty_r = {NumRep{fifo_empty_i}};
        assign ready_r = {NumRep{ready_i}};
        assign flush_r = {NumRep{flush_i}};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= {NumRep{EMPTY}};
        end else begin
            vld_q <= vld_d;
        end
    end

    // Per-replica handshake; every replica registers the majority of all three next states
    always_comb begin
        pop   = '0;
        vld_n = '0;
        vld_d = '0;
        for (int r = 0; r < int'(NumRep); r++) begin
            pop[r] = ~empty_r[r] & (~vld_q[r] | ready_r[r]) & ~flush_r[r];
            if (flush_r[r]) begin
                vld_n[r] = EMPTY;
            end else if (pop[r]) begin
                vld_n[r] = FULL;
            end else if (ready_r[r]) begin
                vld_n[r] = EMPTY;
            end else begin
                vld_n[r] = vld_q[r];
            end
        end
        for (int r = 0; r < int'(NumRep); r++) begin
            vld_d[r] = maj3(vld_n);
        end
    end

    always_comb begin
        load       = maj3(pop);
        vld_vote   = maj3(vld_q);
        ready_vote = maj3(ready_r);
        flush_vote = maj3(flush_r);
        mismatch   = split3(vld_n) | split3(pop) | (|({NumRep{load}} ^ pop));
        if (!TmrStatus) begin
            mismatch = mismatch | split3(vld_q);
        end
    end

    if (TmrStatus) begin : g_tmr_out
        assign fifo_pop_o = pop;
        assign valid_o    = vld_q;
    end else begin : g_voted_out
        assign fifo_pop_o = load;
        assign valid_o    = vld_vote;
    end

    // Single data copy; the ECC codeword is passed through untouched
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= fifo_data_i;
        end
    end

    assign data_o = data_q;

`ifdef REL_FIFO_POP_STAGE_STICKY_FAULT_EN
    logic fault_q;
    logic fault_d;

    assign fault_d = flush_vote ? 1'b0 : (fault_q | mismatch);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault_o = fault_q;
`else
    assign fault_o = mismatch;
`endif

`ifndef SYNTHESIS
    a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (pop & empty_r) == '0);
    a_valid_drop: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $fell(vld_vote) |-> $past(ready_vote || flush_vote));
    a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (vld_vote && !ready_vote) |=> $stable(data_o));
`endif

endmodule

// File: tb/tb_rel_fifo_pop_stage.sv
// Directed bench for rel_fifo_pop_stage: voted-status instance plus a triplicated-status instance.
module tb_rel_fifo_pop_stage;
    localparam int unsigned DW = 39;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush, empty, ready, pop, valid, fault;
    logic [DW-1:0] din, dout;
    logic [2:0]    flush3, empty3, ready3, pop3, valid3;
    logic [DW-1:0] dout3;
    logic          fault3;
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;

    rel_fifo_pop_stage #(.DataWidth(DW), .TmrStatus(1'b0)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .fifo_empty_i (empty),
        .fifo_data_i  (din),
        .fifo_pop_o   (pop),
        .valid_o      (valid),
        .ready_i      (ready),
        .data_o       (dout),
        .fault_o      (fault)
    );

    rel_fifo_pop_stage #(.DataWidth(DW), .TmrStatus(1'b1)) dut_t (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush3),
        .fifo_empty_i (empty3),
        .fifo_data_i  (din),
        .fifo_pop_o   (pop3),
        .valid_o      (valid3),
        .ready_i      (ready3),
        .data_o       (dout3),
        .fault_o      (fault3)
    );

    task automatic test_reset();
        rst_n  = 1'b0;
        flush  = 1'b0;
        empty  = 1'b1;
        ready  = 1'b0;
        din    = '0;
        flush3 = 3'b000;
        empty3 = 3'b111;
        ready3 = 3'b000;
        #12;
        n_checks++;
        if ({valid, pop, fault} !== 3'b000 || dout !== '0)
            $display("FAIL reset_voted: got valid=%0b pop=%0b fault=%0b data=%h want 0 0 0 0", valid, pop, fault, dout);
        else n_pass++;
        n_checks++;
        if ({valid3, pop3, fault3} !== 7'b0 || dout3 !== '0)
            $display("FAIL reset_tmr: got valid=%b pop=%b fault=%0b data=%h want 000 000 0 0", valid3, pop3, fault3, dout3);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        empty = 1'b0; din = DW'(39'h15); ready = 1'b0;
        #1;
        n_checks++;
        if (pop !== 1'b1 || fault !== 1'b0)
            $display("FAIL single_pop: got pop=%0b fault=%0b want 1 0", pop, fault);
        else n_pass++;
        @(negedge clk);
        empty = 1'b1;
        #1;
        n_checks++;
        if (valid !== 1'b1 || dout !== DW'(39'h15) || pop !== 1'b0 || fault !== 1'b0)
            $display("FAIL single_out: got valid=%0b data=%h pop=%0b fault=%0b want 1 15 0 0", valid, dout, pop, fault);
        else n_pass++;
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0)
            $display("FAIL single_drain: got valid=%0b want 0", valid);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [DW-1:0] w [4];
        w = '{DW'(39'h101), DW'(39'h202), DW'(39'h303), DW'(39'h404)};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            empty = 1'b0; din = w[i]; ready = 1'b1;
            #1;
            n_checks++;
            if (pop !== 1'b1 || (i > 0 && (valid !== 1'b1 || dout !== w[(i + 3) % 4])))
                $display("FAIL stream_%0d: got pop=%0b valid=%0b data=%h want 1 %0b %h",
                         i, pop, valid, dout, i > 0, (i > 0) ? w[(i + 3) % 4] : '0);
            else n_pass++;
        end
        @(negedge clk);
        empty = 1'b1;
        #1;
        n_checks++;
        if (valid !== 1'b1 || dout !== w[3] || pop !== 1'b0)
            $display("FAIL stream_last: got valid=%0b data=%h pop=%0b want 1 %h 0", valid, dout, pop, w[3]);
        else n_pass++;
        @(negedge clk);
        ready = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0)
            $display("FAIL stream_drain: got valid=%0b want 0", valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        empty = 1'b0; din = DW'(39'h2A); ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            din = DW'(39'h3B);
            #1;
            n_checks++;
            if (valid !== 1'b1 || dout !== DW'(39'h2A) || pop !== 1'b0)
                $display("FAIL stall_%0d: got valid=%0b data=%h pop=%0b want 1 2a 0", i, valid, dout, pop);
            else n_pass++;
        end
        @(negedge clk);
        ready = 1'b1;
        #1;
        n_checks++;
        if (pop !== 1'b1)
            $display("FAIL stall_release_pop: got pop=%0b want 1", pop);
        else n_pass++;
        @(negedge clk);
        empty = 1'b1;
        #1;
        n_checks++;
        if (valid !== 1'b1 || dout !== DW'(39'h3B))
            $display("FAIL stall_next_word: got valid=%0b data=%h want 1 3b", valid, dout);
        else n_pass++;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_fault_inject();
        @(negedge clk);
        empty = 1'b0; din = DW'(39'h44); ready = 1'b0;
        @(negedge clk);
        empty = 1'b1;
        #1;
        force dut.vld_q = 3'b101;
        #1;
        n_checks++;
        if (valid !== 1'b1 || fault !== 1'b1)
            $display("FAIL upset_detect: got valid=%0b fault=%0b want 1 1", valid, fault);
        else n_pass++;
        release dut.vld_q;
        @(negedge clk);
        #1;
        n_checks++;
        if (dut.vld_q !== 3'b111 || valid !== 1'b1)
            $display("FAIL upset_correct: got vld_q=%b valid=%0b want 111 1", dut.vld_q, valid);
        else n_pass++;
`ifdef REL_FIFO_POP_STAGE_STICKY_FAULT_EN
        n_checks++;
        if (fault !== 1'b1)
            $display("FAIL upset_fault_after: got fault=%0b want 1", fault);
        else n_pass++;
`else
        n_checks++;
        if (fault !== 1'b0)
            $display("FAIL upset_fault_after: got fault=%0b want 0", fault);
        else n_pass++;
`endif
    endtask

    task automatic test_flush();
        @(negedge clk);
        flush = 1'b1; empty = 1'b0; din = DW'(39'h55); ready = 1'b0;
        #1;
        n_checks++;
        if (pop !== 1'b0)
            $display("FAIL flush_no_pop: got pop=%0b want 0", pop);
        else n_pass++;
        @(negedge clk);
        flush = 1'b0; empty = 1'b1;
        #1;
        n_checks++;
        if (valid !== 1'b0 || dout !== DW'(39'h44) || fault !== 1'b0)
            $display("FAIL flush_result: got valid=%0b data=%h fault=%0b want 0 44 0", valid, dout, fault);
        else n_pass++;
    endtask

    task automatic test_flush_with_ready();
        @(negedge clk);
        empty = 1'b0; din = DW'(39'h5A); ready = 1'b0;
        @(negedge clk);
        din = DW'(39'h6B); ready = 1'b1; flush = 1'b1;
        #1;
        n_checks++;
        if (pop !== 1'b0 || valid !== 1'b1 || dout !== DW'(39'h5A))
            $display("FAIL flush_ready_cycle: got pop=%0b valid=%0b data=%h want 0 1 5a", pop, valid, dout);
        else n_pass++;
        @(negedge clk);
        flush = 1'b0; empty = 1'b1; ready = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0 || dout !== DW'(39'h5A))
            $display("FAIL flush_ready_after: got valid=%0b data=%h want 0 5a", valid, dout);
        else n_pass++;
    endtask

    task automatic test_tmr_split_ready();
        @(negedge clk);
        empty3 = 3'b000; din = DW'(39'h66); ready3 = 3'b000;
        #1;
        n_checks++;
        if (pop3 !== 3'b111)
            $display("FAIL tmr_pop: got pop=%b want 111", pop3);
        else n_pass++;
        @(negedge clk);
        empty3 = 3'b111;
        #1;
        n_checks++;
        if (valid3 !== 3'b111 || dout3 !== DW'(39'h66) || fault3 !== 1'b0)
            $display("FAIL tmr_load: got valid=%b data=%h fault=%0b want 111 66 0", valid3, dout3, fault3);
        else n_pass++;
        @(negedge clk);
        ready3 = 3'b011;
        #1;
        n_checks++;
        if (fault3 !== 1'b1 || pop3 !== 3'b000)
            $display("FAIL tmr_split_fault: got fault=%0b pop=%b want 1 000", fault3, pop3);
        else n_pass++;
        @(negedge clk);
        ready3 = 3'b000;
        #1;
        n_checks++;
        if (valid3 !== 3'b000)
            $display("FAIL tmr_voted_empty: got valid=%b want 000", valid3);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        empty = 1'b0; din = DW'(39'h77); ready = 1'b0;
        @(negedge clk);
        empty = 1'b1;
        #1;
        n_checks++;
        if (valid !== 1'b1 || dout !== DW'(39'h77))
            $display("FAIL midrst_pre: got valid=%0b data=%h want 1 77", valid, dout);
        else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0 || dout !== '0 || fault !== 1'b0)
            $display("FAIL midrst_clear: got valid=%0b data=%h fault=%0b want 0 0 0", valid, dout, fault);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_fault_inject();
        test_flush();
        test_flush_with_ready();
        test_tmr_split_ready();
        test_reset_mid();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
